// File: rtl/div_pkg.sv
//------------------------------------------------------------------------------
// Module  : div_pkg
// Brief   : Register offsets and FSM state encodings for the peripheral divider.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package div_pkg;

    localparam logic [4:0] ADDR_A      = 5'h04;
    localparam logic [4:0] ADDR_B      = 5'h08;
    localparam logic [4:0] ADDR_INIT   = 5'h0C;
    localparam logic [4:0] ADDR_Q      = 5'h10;
    localparam logic [4:0] ADDR_R      = 5'h14;
    localparam logic [4:0] ADDR_STATUS = 5'h18;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/div_core.sv
//------------------------------------------------------------------------------
// Module  : div_core
// Brief   : Restoring shift-subtract unsigned divider, one quotient bit per clock.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module div_core
    import div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int              c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dsr;
    logic [c_CW-1:0]  r_cnt;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_dvd_next;

    // The shifted partial remainder keeps its carry bit so a divisor with its
    // MSB set still compares correctly.
    always_comb begin
        w_shift    = {r_rem, r_dvd[WIDTH-1]};
        w_trial    = w_shift - {1'b0, r_dsr};
        w_qbit     = ~w_trial[WIDTH];
        w_rem_next = w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
        w_dvd_next = {r_dvd[WIDTH-2:0], w_qbit};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_dvd     <= '0;
            r_rem     <= '0;
            r_dsr     <= '0;
            r_cnt     <= '0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_dvd   <= dividend;
                        r_dsr   <= divisor;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        done    <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_dvd <= w_dvd_next;
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state   <= S_IDLE;
                        quotient  <= w_dvd_next;
                        remainder <= w_rem_next;
                        done      <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state == S_RUN);

endmodule

`default_nettype wire

// File: rtl/peripheral_div.sv
//------------------------------------------------------------------------------
// Module  : peripheral_div
// Brief   : Memory-mapped divider peripheral: register file, decode, read mux.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module peripheral_div
    import div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_in,
    input  logic             cs,
    input  logic [4:0]       addr,
    input  logic             rd,
    input  logic             wr,
    output logic [31:0]      d_out
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_div0;

    logic             w_wr;
    logic             w_start;
    logic             w_busy;
    logic             w_done;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_r;
    logic [31:0]      w_rdata;

    assign w_wr    = cs & wr;
    assign w_start = w_wr & (addr == ADDR_INIT) & d_in[0];

    div_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .reset     (reset),
        .start     (w_start),
        .dividend  (r_a),
        .divisor   (r_b),
        .busy      (w_busy),
        .done      (w_done),
        .quotient  (w_q),
        .remainder (w_r)
    );

    // div0 only follows an INIT the core actually accepts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_div0 <= 1'b0;
        end else begin
            if (w_wr && addr == ADDR_A) r_a <= d_in;
            if (w_wr && addr == ADDR_B) r_b <= d_in;
            if (w_start && !w_busy)     r_div0 <= (r_b == '0);
        end
    end

    always_comb begin
        w_rdata = 32'h0;
        case (addr)
            ADDR_A:      w_rdata = 32'(r_a);
            ADDR_B:      w_rdata = 32'(r_b);
            ADDR_INIT:   w_rdata = {31'h0, w_busy};
            ADDR_Q:      w_rdata = 32'(w_q);
            ADDR_R:      w_rdata = 32'(w_r);
            ADDR_STATUS: w_rdata = {30'h0, r_div0, w_done};
            default:     w_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)          d_out <= 32'h0;
        else if (cs && rd)  d_out <= w_rdata;
    end

endmodule

`default_nettype wire

// File: tb/tb_peripheral_div.sv
//------------------------------------------------------------------------------
// Module  : tb_peripheral_div
// Brief   : Self-checking bench for peripheral_div (vector table + scoreboard).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_peripheral_div;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] d_in = '0;
    logic             cs = 1'b0;
    logic [4:0]       addr = '0;
    logic             rd = 1'b0;
    logic             wr = 1'b0;
    logic [31:0]      d_out;

    peripheral_div #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .d_in  (d_in),
        .cs    (cs),
        .addr  (addr),
        .rd    (rd),
        .wr    (wr),
        .d_out (d_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] st;
    } vec_t;

    vec_t vecs[8];
    vec_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [15:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] v);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        v = d_out;
    endtask

    task automatic wait_done(input string name);
        logic [31:0] v;
        bit          seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            bus_read(5'h18, v);
            if (v[0]) seen = 1'b1;
        end
        if (!seen) check({name, "_timeout"}, 32'h0, 32'h1);
    endtask

    // Pop the oldest expectation and compare Q, R and STATUS against it.
    task automatic check_result(input string name);
        vec_t        e;
        logic [31:0] v;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 32'h0, 32'h1);
            return;
        end
        e = sb.pop_front();
        bus_read(5'h10, v); check({name, "_q"}, v, e.q);
        bus_read(5'h14, v); check({name, "_r"}, v, e.r);
        bus_read(5'h18, v); check({name, "_status"}, v, e.st);
    endtask

    task automatic push_exp(input logic [15:0] a, input logic [15:0] b);
        vec_t e;
        e.a  = a;
        e.b  = b;
        e.q  = (b == 0) ? 32'h0000_FFFF : 32'(a / b);
        e.r  = (b == 0) ? 32'(a) : 32'(a % b);
        e.st = (b == 0) ? 32'h3 : 32'h1;
        sb.push_back(e);
    endtask

    initial begin
        logic [31:0] v;
        int          first_k;

        vecs[0] = '{a: 16'd100,   b: 16'd7,     q: 32'd14,    r: 32'd2,     st: 32'h1};
        vecs[1] = '{a: 16'd1234,  b: 16'd0,     q: 32'hFFFF,  r: 32'd1234,  st: 32'h3};
        vecs[2] = '{a: 16'd65535, b: 16'd1,     q: 32'd65535, r: 32'd0,     st: 32'h1};
        vecs[3] = '{a: 16'd5,     b: 16'd9,     q: 32'd0,     r: 32'd5,     st: 32'h1};
        vecs[4] = '{a: 16'd65535, b: 16'd65535, q: 32'd1,     r: 32'd0,     st: 32'h1};
        vecs[5] = '{a: 16'd65534, b: 16'd65535, q: 32'd0,     r: 32'd65534, st: 32'h1};
        vecs[6] = '{a: 16'd40000, b: 16'd300,   q: 32'd133,   r: 32'd100,   st: 32'h1};
        vecs[7] = '{a: 16'd0,     b: 16'd3,     q: 32'd0,     r: 32'd0,     st: 32'h1};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_dout", d_out, 32'h0);
        bus_read(5'h18, v); check("reset_status", v, 32'h0);
        bus_read(5'h04, v); check("reset_a", v, 32'h0);

        // Exact latency: busy one cycle after INIT, done first visible WIDTH cycles later.
        bus_write(5'h04, 16'd100);
        bus_write(5'h08, 16'd7);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = 5'h0C; d_in = 16'h1;
        @(negedge clk);
        wr = 1'b0; rd = 1'b1; addr = 5'h0C;
        @(negedge clk);
        check("busy_after_init", d_out, 32'h1);
        addr = 5'h18;
        first_k = -1;
        for (int k = 2; k <= 40 && first_k < 0; k++) begin
            @(negedge clk);
            if (d_out[0]) first_k = k;
        end
        cs = 1'b0; rd = 1'b0;
        check("done_latency", 32'(first_k), 32'(WIDTH + 1));
        bus_read(5'h10, v); check("lat_q", v, 32'd14);
        bus_read(5'h14, v); check("lat_r", v, 32'd2);

        for (int i = 0; i < 8; i++) begin
            bus_write(5'h04, vecs[i].a);
            bus_write(5'h08, vecs[i].b);
            bus_write(5'h0C, 16'h1);
            sb.push_back(vecs[i]);
            wait_done($sformatf("vec%0d", i));
            check_result($sformatf("vec%0d", i));
        end

        // Operand and INIT writes while busy must not disturb the running divide.
        bus_write(5'h04, 16'd1000);
        bus_write(5'h08, 16'd10);
        bus_write(5'h0C, 16'h1);
        push_exp(16'd1000, 16'd10);
        bus_write(5'h04, 16'd7);
        bus_write(5'h08, 16'd3);
        bus_write(5'h0C, 16'h1);
        wait_done("busy_ign");
        check_result("busy_ign");
        bus_read(5'h04, v); check("busy_wr_a", v, 32'd7);
        bus_write(5'h0C, 16'h1);
        push_exp(16'd7, 16'd3);
        wait_done("after_ign");
        check_result("after_ign");

        // Reset mid-run discards everything.
        bus_write(5'h04, 16'd500);
        bus_write(5'h08, 16'd5);
        bus_write(5'h0C, 16'h1);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_dout", d_out, 32'h0);
        bus_read(5'h0C, v); check("rst_mid_busy", v, 32'h0);
        bus_read(5'h18, v); check("rst_mid_status", v, 32'h0);
        bus_read(5'h10, v); check("rst_mid_q", v, 32'h0);
        bus_read(5'h14, v); check("rst_mid_r", v, 32'h0);
        repeat (20) @(negedge clk);
        bus_read(5'h18, v); check("rst_no_done", v, 32'h0);

        // INIT with d_in[0]=0 is ignored.
        bus_write(5'h04, 16'd9);
        bus_write(5'h08, 16'd2);
        bus_write(5'h0C, 16'h2);
        bus_read(5'h0C, v); check("init_bit0_zero", v, 32'h0);

        // cs low: no write, d_out holds; unmapped read returns zero.
        bus_write(5'h04, 16'h1111);
        bus_read(5'h04, v); check("cs_pre_a", v, 32'h1111);
        @(negedge clk);
        cs = 1'b0; wr = 1'b1; rd = 1'b1; addr = 5'h04; d_in = 16'h0055;
        @(negedge clk);
        addr = 5'h1C;
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
        check("cs0_dout_hold", d_out, 32'h1111);
        bus_read(5'h04, v); check("cs0_a_kept", v, 32'h1111);
        bus_read(5'h1C, v); check("unmapped_read", v, 32'h0);
        bus_write(5'h10, 16'h1234);
        bus_read(5'h10, v); check("q_readonly", v, 32'h0);

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
